// File: rtl/msix_tlp_pkg.sv
// Shared types and constants for the MSI-X to PCIe Memory Write TLP path:
// request record, 4-DW MWr header layout, FSM states and the header builder.
package msix_tlp_pkg;

  localparam logic [2:0] MWR32_FMT = 3'b010;
  localparam logic [2:0] MWR64_FMT = 3'b011;
  localparam logic [4:0] MWR_TYPE  = 5'b00000;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
    logic        drop;
  } t_msix_req;

  // dw0 sits in the least significant bits so the header maps onto tdata[127:0].
  typedef struct packed {
    logic [31:0] dw3;
    logic [31:0] dw2;
    logic [31:0] dw1;
    logic [31:0] dw0;
  } t_tlp_mwr_hdr;

  typedef enum logic [1:0] {IDLE, BUILD, SEND} t_state;

  // Single-DW posted write: length 1, TC/attr/TD/EP zero, all byte enables on DW0 only.
  function automatic t_tlp_mwr_hdr build_mwr_hdr(input logic [63:0] addr,
                                                 input logic [15:0] req_id);
    t_tlp_mwr_hdr hdr;
    logic [31:0]  addr_lo;
    addr_lo = addr[31:0] & 32'hFFFF_FFFC;
    hdr.dw1 = {req_id, 8'h00, 4'h0, 4'hF};
    if (addr[63:32] == 32'h0) begin
      hdr.dw0 = {MWR32_FMT, MWR_TYPE, 14'h0, 10'd1};
      hdr.dw2 = addr_lo;
      hdr.dw3 = 32'h0;
    end else begin
      hdr.dw0 = {MWR64_FMT, MWR_TYPE, 14'h0, 10'd1};
      hdr.dw2 = addr[63:32];
      hdr.dw3 = addr_lo;
    end
    return hdr;
  endfunction

endpackage

// File: rtl/msix_req_fifo.sv
// Synchronous request FIFO with occupancy count and a registered "will have
// space next cycle" flag used directly as the upstream tready.
module msix_req_fifo
  import msix_tlp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  t_msix_req push_data,
  input  logic      pop,
  output t_msix_req pop_data,
  output logic      empty,
  output logic      ready
);

  localparam int AW = $clog2(DEPTH);

  t_msix_req       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [AW:0]     count_d;

  assign count_d  = count + (AW+1)'(push) - (AW+1)'(pop);
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // NOTE: storage is left unreset; the count gates every read, so reset only
  // needs to clear pointers and occupancy, and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_d;
      ready <= (count_d < (AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/msix_mwr_tlp_gen.sv
// Buffers MSI-X requests and emits each as a single-beat, single-DW posted MWr TLP.
// Build option: define MSIX_MWR_ADDR_CHK_EN to drop requests with a misaligned address.
module msix_mwr_tlp_gen
  import msix_tlp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TX_DATA_W  = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_msix_valid,
  input  logic [63:0]          i_msix_addr,
  input  logic [31:0]          i_msix_data,
  output logic                 o_msix_tready,
  input  logic [15:0]          i_req_id,
  input  logic                 i_tx_en,
  output logic                 o_tx_tvalid,
  input  logic                 i_tx_tready,
  output logic [TX_DATA_W-1:0] o_tx_tdata,
  output logic                 o_tx_tlast,
  output logic                 o_tx_tuser,
  output logic [15:0]          o_sent_cnt,
  output logic [7:0]           o_drop_cnt
);

  t_state       state, state_d;
  t_msix_req    push_req, pop_req, req_q;
  t_tlp_mwr_hdr hdr;
  logic         fifo_empty, fifo_ready;
  logic         push, pop, addr_bad, tx_done;
  logic [159:0] beat_q;
  logic         tvalid_q, tuser_q;
  logic [15:0]  sent_q;

`ifdef MSIX_MWR_ADDR_CHK_EN
  assign addr_bad = |i_msix_addr[1:0];
`else
  assign addr_bad = 1'b0;
`endif

  assign push     = i_msix_valid & fifo_ready;
  assign push_req = {i_msix_addr, i_msix_data, addr_bad};

  msix_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .pop_data  (pop_req),
    .empty     (fifo_empty),
    .ready     (fifo_ready)
  );

  assign tx_done = (state == SEND) && i_tx_tready;
  assign hdr     = build_mwr_hdr(req_q.addr, i_req_id);

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty && i_tx_en) begin
          pop     = 1'b1;
          state_d = BUILD;
        end
      end
      BUILD: state_d = req_q.drop ? IDLE : SEND;
      SEND: begin
        if (i_tx_tready) begin
          if (!fifo_empty && i_tx_en) begin
            pop     = 1'b1;
            state_d = BUILD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_q    <= '0;
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      beat_q   <= '0;
      sent_q   <= '0;
    end else begin
      state <= state_d;
      if (pop) req_q <= pop_req;
      if (state == BUILD && !req_q.drop) begin
        tvalid_q <= 1'b1;
        tuser_q  <= |req_q.addr[63:32];
        beat_q   <= {req_q.data, hdr};
      end else if (tx_done) begin
        tvalid_q <= 1'b0;
      end
      if (tx_done && sent_q != 16'hFFFF) sent_q <= sent_q + 16'd1;
    end
  end

`ifdef MSIX_MWR_ADDR_CHK_EN
  logic [7:0] drop_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (state == BUILD && req_q.drop && drop_q != 8'hFF) begin
      drop_q <= drop_q + 8'd1;
    end
  end
  assign o_drop_cnt = drop_q;
`else
  assign o_drop_cnt = 8'h00;
`endif

  assign o_msix_tready = fifo_ready;
  assign o_tx_tvalid   = tvalid_q;
  assign o_tx_tlast    = tvalid_q;
  assign o_tx_tuser    = tuser_q;
  assign o_tx_tdata    = TX_DATA_W'(beat_q);
  assign o_sent_cnt    = sent_q;

endmodule

// File: tb/tb_msix_mwr_tlp_gen.sv
// Directed self-checking bench for msix_mwr_tlp_gen with hand-computed TLP images.
module tb_msix_mwr_tlp_gen;

  localparam int TX_DATA_W = 256;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 i_msix_valid = 1'b0;
  logic [63:0]          i_msix_addr = '0;
  logic [31:0]          i_msix_data = '0;
  logic                 o_msix_tready;
  logic [15:0]          i_req_id = 16'hABCD;
  logic                 i_tx_en = 1'b1;
  logic                 o_tx_tvalid;
  logic                 i_tx_tready = 1'b1;
  logic [TX_DATA_W-1:0] o_tx_tdata;
  logic                 o_tx_tlast;
  logic                 o_tx_tuser;
  logic [15:0]          o_sent_cnt;
  logic [7:0]           o_drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  msix_mwr_tlp_gen #(.FIFO_DEPTH(4), .TX_DATA_W(TX_DATA_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_msix_valid  (i_msix_valid),
    .i_msix_addr   (i_msix_addr),
    .i_msix_data   (i_msix_data),
    .o_msix_tready (o_msix_tready),
    .i_req_id      (i_req_id),
    .i_tx_en       (i_tx_en),
    .o_tx_tvalid   (o_tx_tvalid),
    .i_tx_tready   (i_tx_tready),
    .o_tx_tdata    (o_tx_tdata),
    .o_tx_tlast    (o_tx_tlast),
    .o_tx_tuser    (o_tx_tuser),
    .o_sent_cnt    (o_sent_cnt),
    .o_drop_cnt    (o_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [63:0] a, input logic [31:0] d, output bit acc);
    i_msix_valid = 1'b1;
    i_msix_addr  = a;
    i_msix_data  = d;
    acc          = o_msix_tready;
    step();
    i_msix_valid = 1'b0;
  endtask

  task automatic wait_tvalid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= max; i++) begin
      if (o_tx_tvalid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (i < max) step();
    end
  endtask

  task automatic idle_watch(input int cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (o_tx_tvalid !== 1'b0) seen = 1'b1;
    end
  endtask

  initial begin
    bit acc, ok, seen;
    int n_acc;
    logic [31:0] exp_bp [5];
    logic [31:0] exp_en [2];
    exp_bp = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
    exp_en = '{32'hB0, 32'hB1};

    // Reset state
    step();
    step();
    check("rst_tready", o_msix_tready, 1'b0);
    check("rst_tvalid", o_tx_tvalid, 1'b0);
    check("rst_tdata", o_tx_tdata, '0);
    check("rst_cnts", {o_sent_cnt, o_drop_cnt}, 24'h0);
    rst_n = 1'b1;
    check("rst_tready_hold", o_msix_tready, 1'b0);
    step();
    check("tready_after_rst", o_msix_tready, 1'b1);

    // MWr32 with minimum latency
    push_one(64'h0000_0000_FEE0_1000, 32'h0000_0041, acc);
    check("t1_acc", acc, 1'b1);
    check("t1_lat0", o_tx_tvalid, 1'b0);
    step();
    check("t1_lat1", o_tx_tvalid, 1'b0);
    step();
    check("t1_lat2", o_tx_tvalid, 1'b1);
    check("t1_fmt", o_tx_tdata[31:29], 3'b010);
    check("t1_tdata", o_tx_tdata,
          {96'h0, 32'h0000_0041, 32'h0, 32'hFEE0_1000, 32'hABCD_000F, 32'h4000_0001});
    check("t1_tuser", o_tx_tuser, 1'b0);
    check("t1_tlast", o_tx_tlast, 1'b1);
    step();
    check("t1_sent", o_sent_cnt, 16'd1);
    check("t1_tvalid_drop", o_tx_tvalid, 1'b0);

    // MWr64
    push_one(64'h0000_0001_0000_0040, 32'h0000_1234, acc);
    wait_tvalid(6, ok);
    check("t2_tvalid", ok, 1'b1);
    check("t2_fmt", o_tx_tdata[31:29], 3'b011);
    check("t2_tdata", o_tx_tdata,
          {96'h0, 32'h0000_1234, 32'h0000_0040, 32'h0000_0001, 32'hABCD_000F, 32'h6000_0001});
    check("t2_tuser", o_tx_tuser, 1'b1);
    step();
    check("t2_sent", o_sent_cnt, 16'd2);

    // Backpressure: six back-to-back offers into a depth-4 FIFO
    i_tx_tready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      i_msix_valid = 1'b1;
      i_msix_addr  = {32'h0, 32'h1000_0000 + 32'(i * 4)};
      i_msix_data  = 32'hA0 + 32'(i);
      if (o_msix_tready) n_acc++;
      step();
    end
    i_msix_valid = 1'b0;
    check("t3_acc_cnt", n_acc, 5);
    check("t3_full_tready", o_msix_tready, 1'b0);
    for (int i = 0; i < 14; i++) begin
      check("t3_hold", {o_tx_tvalid, o_tx_tuser, o_tx_tdata[159:0]},
            {1'b1, 1'b0, 32'hA0, 32'h0, 32'h1000_0000, 32'hABCD_000F, 32'h4000_0001});
      step();
    end
    i_tx_tready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_tvalid(6, ok);
      check("t3_drain_valid", ok, 1'b1);
      check("t3_drain_data", o_tx_tdata[159:128], exp_bp[k]);
      step();
      if (k == 0) check("t3_tready_reopen", o_msix_tready, 1'b1);
    end
    check("t3_sent", o_sent_cnt, 16'd7);

    // Dequeue disabled holds requests in the FIFO
    i_tx_en = 1'b0;
    push_one(64'h0000_0000_2000_0000, 32'hB0, acc);
    push_one(64'h0000_0000_2000_0004, 32'hB1, acc);
    idle_watch(8, seen);
    check("t4_no_tvalid", seen, 1'b0);
    i_tx_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_tvalid(6, ok);
      check("t4_valid", ok, 1'b1);
      check("t4_data", o_tx_tdata[159:128], exp_en[k]);
      step();
    end
    check("t4_sent", o_sent_cnt, 16'd9);

    // Misaligned address
    push_one(64'h0000_0000_FEE0_1002, 32'h55, acc);
`ifdef MSIX_MWR_ADDR_CHK_EN
    idle_watch(8, seen);
    check("t5_no_tlp", seen, 1'b0);
    check("t5_drop", o_drop_cnt, 8'd1);
    check("t5_sent", o_sent_cnt, 16'd9);
`else
    wait_tvalid(6, ok);
    check("t5_valid", ok, 1'b1);
    check("t5_dw2", o_tx_tdata[95:64], 32'hFEE0_1000);
    check("t5_data", o_tx_tdata[159:128], 32'h55);
    step();
    check("t5_drop", o_drop_cnt, 8'd0);
    check("t5_sent", o_sent_cnt, 16'd10);
`endif

    // Reset while in SEND with three requests queued
    i_tx_tready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      push_one({32'h0, 32'h3000_0000 + 32'(i * 4)}, 32'hC0 + 32'(i), acc);
      if (acc) n_acc++;
    end
    check("t6_acc_cnt", n_acc, 4);
    wait_tvalid(6, ok);
    check("t6_in_send", ok, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_tvalid", o_tx_tvalid, 1'b0);
    check("t6_rst_tready", o_msix_tready, 1'b0);
    check("t6_rst_tdata", o_tx_tdata, '0);
    step();
    step();
    rst_n = 1'b1;
    i_tx_tready = 1'b1;
    idle_watch(10, seen);
    check("t6_no_tlp", seen, 1'b0);
    check("t6_cnts", {o_sent_cnt, o_drop_cnt}, 24'h0);
    check("t6_tready", o_msix_tready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msix_mwr_tlp_gen.md
Name: msix_mwr_tlp_gen

Overview:
- PCIe-side consumer of the MSI-X request interface (addr/data/valid with tready backpressure) produced by the interrupt wrapper.
- Buffers each MSI-X request and converts it into a single-DW posted Memory Write TLP on a single-beat AXI-S TX stream toward the PCIe TX arbiter.
- Chooses 3DW or 4DW header from the address.
- Provides sent and dropped counters for CSR visibility.

Parameters:
- FIFO_DEPTH, 4, request buffer entries; power of two, at least 2.
- TX_DATA_W, 256, TX tdata width; at least 160.

Ports:
- clk  in  1  block clock.
- rst_n  in  1  asynchronous active-low reset.
- i_msix_valid  in  1  MSI-X request valid.
- i_msix_addr  in  64  MSI-X message address from the table entry.
- i_msix_data  in  32  MSI-X message data.
- o_msix_tready  out  1  request accepted when i_msix_valid and o_msix_tready are both high.
- i_req_id  in  16  requester ID {bus, dev, fn}; quasi-static.
- i_tx_en  in  1  dequeue enable; low holds requests in the FIFO.
- o_tx_tvalid  out  1  TLP valid.
- i_tx_tready  in  1  TX arbiter ready.
- o_tx_tdata  out  TX_DATA_W  [127:0] header DW0..DW3, [159:128] payload, upper bits zero.
- o_tx_tlast  out  1  always equals o_tx_tvalid (single beat).
- o_tx_tuser  out  1  1 means 4DW header.
- o_sent_cnt  out  16  saturating count of completed TX handshakes.
- o_drop_cnt  out  8  saturating count of dropped requests.

Behaviour:
- Reset, asynchronous: FIFO empty, FSM in IDLE, o_tx_tvalid=0, o_tx_tdata=0, o_tx_tuser=0, counters=0. o_msix_tready=0 while rst_n is low, and 1 from the first clock after deassertion.
- o_msix_tready is registered and equals "FIFO count < FIFO_DEPTH" as predicted for the next cycle, so a full FIFO never accepts.
  - Simultaneous push and pop on a full FIFO: tready stays 0 in that cycle and rises the next cycle.
- Push stores {addr, data} and drop flag. The drop flag is set only when the MSIX_MWR_ADDR_CHK_EN feature is compiled in (see Optional Feature).
- FSM:
  - IDLE: if FIFO is non-empty and i_tx_en=1, pop one entry and go to BUILD.
  - BUILD: if the entry is flagged drop, increment o_drop_cnt and return to IDLE. Otherwise register the TLP, set o_tx_tvalid=1 and go to SEND.
  - SEND: hold tvalid, tdata and tuser stable until i_tx_tready=1. On the handshake cycle, increment o_sent_cnt. If the FIFO is non-empty and i_tx_en=1, pop and go to BUILD in the same cycle; otherwise drop tvalid and go to IDLE.
- Minimum latency: request accepted at cycle N, popped at N+1, o_tx_tvalid high at N+2.
- Throughput: one TLP per 2 cycles under continuous ready.
- Header rules:
  - addr[63:32]==0 gives MWr32: fmt=3'b010, type=5'b00000, DW2=addr[31:2]<<2, DW3=0, tuser=0.
  - Otherwise MWr64: fmt=3'b011, DW2=addr[63:32], DW3=addr[31:2]<<2, tuser=1.
  - DW0: length=10'd1, TC=0, attr=0, TD=0, EP=0.
  - DW1: {i_req_id, tag=8'h00, lastBE=4'h0, firstBE=4'hF}.
  - Payload DW = i_msix_data, carried unchanged.
- i_tx_en deasserted in SEND does not abort the TLP in flight; it only blocks the next pop.
- Counters saturate at all-ones and never wrap.
- Reset mid-SEND discards the TLP in flight and all buffered requests; no partial beat is emitted after reset.

Optional Feature:
- Macro: MSIX_MWR_ADDR_CHK_EN.
- Compiled in: a request with addr[1:0]!=0 is flagged drop on push. It is consumed without emitting a TLP, and o_drop_cnt increments in its BUILD cycle.
- Compiled out: addr[1:0] is ignored (forced to 0 in the header), no request is ever dropped, and o_drop_cnt is tied to 0.

Decomposition:
- Shared package msix_tlp_pkg:
  - fmt/type constants MWR32_FMT, MWR64_FMT, MWR_TYPE.
  - typedef t_msix_req {addr, data, drop}.
  - typedef t_tlp_mwr_hdr (4 DW packed).
  - FSM state enum {IDLE, BUILD, SEND}.
- Sub-module msix_req_fifo: synchronous FIFO with count, registered full prediction and async reset. The top holds the FSM, header build and counters.

Test Plan:
- addr=64'h0000_0000_FEE0_1000, data=32'h0000_0041, tready held high:
  - TLP at N+2 with DW0[31:29]=3'b010, DW2=32'hFEE0_1000, tdata[159:128]=32'h41, tuser=0.
  - o_sent_cnt=1.
- addr=64'h0000_0001_0000_0040, data=32'h1234: DW0[31:29]=3'b011, DW2=32'h1, DW3=32'h40, tuser=1.
- i_tx_tready=0 for 20 cycles with 6 back-to-back requests (FIFO_DEPTH=4):
  - o_msix_tready falls after the FIFO fills; the TLP stays stable under backpressure.
  - After tready rises, exactly the accepted requests emerge in order, and o_sent_cnt equals the accepted count.
- i_tx_en=0 with 2 requests queued: no tvalid. Set i_tx_en=1: 2 TLPs, in order.
- With MSIX_MWR_ADDR_CHK_EN and addr=...1002: no TLP, o_drop_cnt=1. Same stimulus without the macro: one TLP with DW2=...1000.
- Assert rst_n low while in SEND with 3 queued requests: tvalid goes to 0 immediately. After reset releases, the FIFO is empty, counters are 0, and no TLP is emitted.
